// File: rtl/inst_test_seq.sv
// inst_test_seq: regression sequencer that runs TEST_NUM instruction test
// programs on the core one after another. For each test it requests an image
// load, holds the core in reset, releases it, then watches the core's data
// stores for a tohost write that reports pass/fail. A test ends on a
// tohost result or on a per-test timeout.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           one-cycle pulse, begins the sequence at test 0 (ignored while busy)
//   abort           level, ends the sequence at once (current test not recorded)
//   load_req/ack    image-load handshake (see below); load_idx = test_idx
//   core_rst_n      active-low core reset, high only while the test runs
//   th_we/addr/wdata core data-store port, snooped for tohost writes
//   test_idx        current (or last) test index
//   busy, done      sequence in progress / finished (done holds until next start)
//   pass_vec, fail_vec, tmo_vec  per-test result bits (exactly one per recorded test)
//   pass_cnt        number of passed tests
//   last_fail_code  th_wdata>>1 of the most recent failing tohost write
//   state_dbg       current FSM state encoding, for observation only
//
// Load handshake: load_req rises on entry to LOAD and stays high until
// load_ack is sampled high at a clk edge; that edge completes the load.
// load_ack may already be high in the first load_req cycle. load_ack is
// ignored whenever load_req is low. abort takes priority over load_ack.
module inst_test_seq #(
  parameter int              TEST_NUM     = 37,
  parameter int              IDX_W        = 6,
  parameter int              RST_CYC      = 1,
  parameter int              TIMEOUT_CYC  = 500,
  parameter int              CNT_W        = 16,
  parameter int              ADDR_W       = 32,
  parameter int              DATA_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000,
  parameter bit              STOP_ON_FAIL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                load_req,
  output logic [IDX_W-1:0]    load_idx,
  input  logic                load_ack,
  output logic                core_rst_n,
  input  logic                th_we,
  input  logic [ADDR_W-1:0]   th_addr,
  input  logic [DATA_W-1:0]   th_wdata,
  output logic [IDX_W-1:0]    test_idx,
  output logic                busy,
  output logic                done,
  output logic [TEST_NUM-1:0] pass_vec,
  output logic [TEST_NUM-1:0] fail_vec,
  output logic [TEST_NUM-1:0] tmo_vec,
  output logic [IDX_W:0]      pass_cnt,
  output logic [DATA_W-1:0]   last_fail_code,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RESET  = 3'd2,
    S_RUN    = 3'd3,
    S_RECORD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    R_PASS = 2'd0,
    R_FAIL = 2'd1,
    R_TMO  = 2'd2
  } res_t;

  state_t             state;
  res_t               res;
  logic [CNT_W-1:0]   cnt;
  logic               hit;
  logic [TEST_NUM-1:0] bit_sel;

  // Registered control outputs are loaded together with the next state so
  // they always match the state register: {load_req, core_rst_n, busy, done}.
  function automatic logic [3:0] flags(input state_t s);
    case (s)
      S_LOAD:   flags = 4'b1010;
      S_RESET:  flags = 4'b0010;
      S_RUN:    flags = 4'b0110;
      S_RECORD: flags = 4'b0010;
      S_DONE:   flags = 4'b0001;
      default:  flags = 4'b0000;
    endcase
  endfunction

  assign hit       = th_we && (th_addr == TOHOST_ADDR);
  assign bit_sel   = TEST_NUM'(1) << test_idx;
  assign load_idx  = test_idx;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      {load_req, core_rst_n, busy, done} <= 4'b0000;
      res            <= R_PASS;
      cnt            <= '0;
      test_idx       <= '0;
      pass_vec       <= '0;
      fail_vec       <= '0;
      tmo_vec        <= '0;
      pass_cnt       <= '0;
      last_fail_code <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // abort in the same cycle as start wins: stay put.
          if (start && !abort) begin
            pass_vec       <= '0;
            fail_vec       <= '0;
            tmo_vec        <= '0;
            pass_cnt       <= '0;
            last_fail_code <= '0;
            test_idx       <= '0;
            state          <= S_LOAD;
            {load_req, core_rst_n, busy, done} <= flags(S_LOAD);
          end
        end

        S_LOAD: begin
          if (abort) begin
            state <= S_DONE;
            {load_req, core_rst_n, busy, done} <= flags(S_DONE);
          end else if (load_ack) begin
            cnt   <= '0;
            state <= S_RESET;
            {load_req, core_rst_n, busy, done} <= flags(S_RESET);
          end
        end

        S_RESET: begin
          if (abort) begin
            state <= S_DONE;
            {load_req, core_rst_n, busy, done} <= flags(S_DONE);
          end else if (cnt == CNT_W'(RST_CYC - 1)) begin
            cnt   <= '0;
            state <= S_RUN;
            {load_req, core_rst_n, busy, done} <= flags(S_RUN);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          // A result on the last allowed cycle beats the timeout because the
          // hit checks come first; a tohost write of 0 is not a result.
          if (abort) begin
            state <= S_DONE;
            {load_req, core_rst_n, busy, done} <= flags(S_DONE);
          end else if (hit && th_wdata == DATA_W'(1)) begin
            res   <= R_PASS;
            state <= S_RECORD;
            {load_req, core_rst_n, busy, done} <= flags(S_RECORD);
          end else if (hit && th_wdata > DATA_W'(1)) begin
            res            <= R_FAIL;
            last_fail_code <= th_wdata >> 1;
            state          <= S_RECORD;
            {load_req, core_rst_n, busy, done} <= flags(S_RECORD);
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            res   <= R_TMO;
            state <= S_RECORD;
            {load_req, core_rst_n, busy, done} <= flags(S_RECORD);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RECORD: begin
          if (abort) begin
            state <= S_DONE;
            {load_req, core_rst_n, busy, done} <= flags(S_DONE);
          end else begin
            case (res)
              R_PASS: begin
                pass_vec <= pass_vec | bit_sel;
                pass_cnt <= pass_cnt + (IDX_W+1)'(1);
              end
              R_FAIL:  fail_vec <= fail_vec | bit_sel;
              default: tmo_vec  <= tmo_vec | bit_sel;
            endcase
            if (test_idx == IDX_W'(TEST_NUM - 1) || (STOP_ON_FAIL && res != R_PASS)) begin
              state <= S_DONE;
              {load_req, core_rst_n, busy, done} <= flags(S_DONE);
            end else begin
              test_idx <= test_idx + IDX_W'(1);
              state    <= S_LOAD;
              {load_req, core_rst_n, busy, done} <= flags(S_LOAD);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          {load_req, core_rst_n, busy, done} <= flags(S_IDLE);
        end
      endcase
    end
  end

endmodule
